// File: rtl/spongent_squeeze_if.sv
// Signal bundle for the Spongent squeeze stage.
// It carries three groups of signals: the start request with the absorbed
// state, the RATE-wide digest block stream, and the request/response link
// to the external permutation engine.
interface spongent_squeeze_if #(
  parameter int STATE_W = 264,
  parameter int RATE    = 8,
  parameter int HASH_W  = 256
);
  // start request from the absorb stage
  logic               en;
  logic [STATE_W-1:0] state_in;
  // digest block stream
  logic [RATE-1:0]    blk_out;
  logic               blk_valid;
  logic               blk_ready;
  // permutation engine link
  logic               perm_start;
  logic [STATE_W-1:0] perm_state_out;
  logic [STATE_W-1:0] perm_state_in;
  logic               perm_done;
  // parallel digest
  logic [HASH_W-1:0]  hash_out;
  logic               rdy;

  // the squeeze block itself
  modport master (
    input  en, state_in, blk_ready, perm_state_in, perm_done,
    output blk_out, blk_valid, perm_start, perm_state_out, hash_out, rdy
  );

  // the surroundings: absorb stage, consumer and permutation engine
  modport slave (
    output en, state_in, blk_ready, perm_state_in, perm_done,
    input  blk_out, blk_valid, perm_start, perm_state_out, hash_out, rdy
  );
endinterface

// File: rtl/spongent_squeeze.sv
// Spongent squeeze phase.
// The block captures the absorbed state when en is seen. It then emits the
// digest RATE bits at a time and requests one external permutation between
// consecutive blocks. Every accepted block is also shifted into a parallel
// digest register, so the first block ends up in the MSBs.
// HASH_W must be a multiple of RATE.
module spongent_squeeze #(
  parameter int STATE_W = 264,
  parameter int RATE    = 8,
  parameter int HASH_W  = 256
) (
  input logic                clk,
  input logic                rst,
  spongent_squeeze_if.master io
);

  localparam int NBLK  = HASH_W / RATE;
  localparam int CNT_W = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NBLK - 1);

  typedef enum logic [1:0] {
    IDLE,
    OUT,
    PERM,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [STATE_W-1:0] work_q, work_d;      // working sponge state
  logic [STATE_W-1:0] pso_q, pso_d;        // copy handed to the engine
  logic [CNT_W-1:0]   cnt_q, cnt_d;        // index of the block on offer
  logic [HASH_W-1:0]  hash_q, hash_d;      // assembled digest
  logic               perm_start_q, perm_start_d;

  // Next-state and datapath updates for the squeeze sequencer
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    work_d       = work_q;
    pso_d        = pso_q;
    cnt_d        = cnt_q;
    hash_d       = hash_q;
    perm_start_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (io.en) begin
          work_d  = io.state_in;
          cnt_d   = '0;
          hash_d  = '0;
          state_d = OUT;
        end
      end

      OUT: begin
        if (io.blk_ready) begin
          hash_d = (hash_q << RATE) | HASH_W'(work_q[RATE-1:0]);
          if (cnt_q == LAST_BLK) begin
            state_d = DONE;
          end else begin
            cnt_d        = cnt_q + CNT_W'(1);
            pso_d        = work_q;
            perm_start_d = 1'b1;
            state_d      = PERM;
          end
        end
      end

      PERM: begin
        // A done that arrives together with the request belongs to no
        // request of ours, so it is only accepted after the first cycle.
        if (io.perm_done && !perm_start_q) begin
          work_d  = io.perm_state_in;
          state_d = OUT;
        end
      end

      DONE: begin
        // A held en must not restart the squeeze; only en=0 re-arms it.
        if (!io.en) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the wide state and digest registers are reset as well. That
    // keeps every output at zero right out of reset, not merely the
    // control bits.
    if (!rst) begin
      state_q      <= IDLE;
      work_q       <= '0;
      pso_q        <= '0;
      cnt_q        <= '0;
      hash_q       <= '0;
      perm_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here. Every flop then samples the
      // pre-edge values computed in the always_comb above.
      state_q      <= state_d;
      work_q       <= work_d;
      pso_q        <= pso_d;
      cnt_q        <= cnt_d;
      hash_q       <= hash_d;
      perm_start_q <= perm_start_d;
    end
  end

  // Outputs come straight from registers or the current state
  assign io.blk_valid      = (state_q == OUT);
  assign io.blk_out        = (state_q == OUT) ? work_q[RATE-1:0] : '0;
  assign io.perm_start     = perm_start_q;
  assign io.perm_state_out = pso_q;
  assign io.hash_out       = hash_q;
  assign io.rdy            = (state_q == DONE);

endmodule

// File: tb/tb_spongent_squeeze.sv
// Testbench for spongent_squeeze.
// A small 32-bit configuration runs against a stub engine. The stub rotates
// the state right by 8 bits and answers 2 cycles after each request. The
// default 264/256 configuration runs against an identity engine.
module tb_spongent_squeeze;

  localparam int SW   = 32;
  localparam int R    = 8;
  localparam int HW   = 32;
  localparam int NB   = HW / R;
  localparam int LAT  = 2;
  localparam int BASE_CYC = NB + (NB - 1) * (LAT + 1) + 1;
  localparam int BSW  = 264;
  localparam int BHW  = 256;
  localparam int BNB  = BHW / R;
  localparam int BIG_CYC = BNB + (BNB - 1) * (LAT + 1) + 1;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  spongent_squeeze_if #(.STATE_W(SW), .RATE(R), .HASH_W(HW)) s_if ();
  spongent_squeeze_if #(.STATE_W(BSW), .RATE(R), .HASH_W(BHW)) b_if ();

  spongent_squeeze #(.STATE_W(SW), .RATE(R), .HASH_W(HW)) dut_s (
    .clk(clk), .rst(rst), .io(s_if)
  );
  spongent_squeeze #(.STATE_W(BSW), .RATE(R), .HASH_W(BHW)) dut_b (
    .clk(clk), .rst(rst), .io(b_if)
  );

  always #5 clk = ~clk;

  // small-config stub engine: rotate right by RATE, done LAT cycles after start
  logic          stub_done = 1'b0;
  logic          inj_done  = 1'b0;
  logic [SW-1:0] stub_state = '0;
  logic [SW-1:0] inj_state  = '0;
  int            stub_cnt   = 0;
  assign s_if.perm_done     = stub_done | inj_done;
  assign s_if.perm_state_in = inj_done ? inj_state : stub_state;

  initial forever begin
    @(negedge clk);
    stub_done = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        stub_done  = 1'b1;
        stub_state = {s_if.perm_state_out[R-1:0], s_if.perm_state_out[SW-1:R]};
      end
    end
    if (s_if.perm_start) stub_cnt = LAT;
  end

  // default-config stub engine: identity permutation
  logic           b_done = 1'b0;
  logic [BSW-1:0] b_state = '0;
  int             b_cnt   = 0;
  assign b_if.perm_done     = b_done;
  assign b_if.perm_state_in = b_state;

  initial forever begin
    @(negedge clk);
    b_done = 1'b0;
    if (b_cnt > 0) begin
      b_cnt--;
      if (b_cnt == 0) begin
        b_done  = 1'b1;
        b_state = b_if.perm_state_out;
      end
    end
    if (b_if.perm_start) b_cnt = LAT;
  end

  // Reference model. With the rotating engine, block k is byte k of the
  // absorbed state. That block sits at bit position HW - R*(k+1) of the digest.
  function automatic logic [HW-1:0] ref_hash(input logic [SW-1:0] s);
    logic [HW-1:0] h;
    h = '0;
    for (int k = 0; k < NB; k++) h = h | (HW'(s[k*R +: R]) << (HW - R * (k + 1)));
    return h;
  endfunction

  // results of the most recent run_small call
  logic [R-1:0] got_q[$];
  int n_perm, n_stall, cyc, hold_bad, stall_perm;

  // One complete squeeze on the small DUT. Runs from an idle FSM until rdy
  // is seen or the cycle budget runs out.
  task automatic run_small(input logic [SW-1:0] s, input bit en_hold,
                           input int stall_blk, input int stall_len,
                           input bit rnd_ready, input bit inj_out, input bit inj_coinc);
    int           stall_left;
    bit           prev_wait, did_inj, rdy_now;
    logic [R-1:0] prev_blk;
    got_q.delete();
    n_perm = 0; n_stall = 0; cyc = 0; hold_bad = 0; stall_perm = 0;
    stall_left = stall_len; prev_wait = 1'b0; prev_blk = '0; did_inj = 1'b0;
    s_if.state_in  = s;
    s_if.en        = 1'b1;
    s_if.blk_ready = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      inj_done = 1'b0;
      if (!en_hold) s_if.en = 1'b0;
      if (s_if.rdy) break;
      if (cyc > 400) break;
      if (s_if.perm_start) begin
        n_perm++;
        if (prev_wait) stall_perm++;
      end
      if (prev_wait && (!s_if.blk_valid || s_if.blk_out !== prev_blk)) hold_bad++;
      prev_wait = 1'b0;
      if (s_if.blk_valid) begin
        rdy_now = 1'b1;
        if (got_q.size() == stall_blk && stall_left > 0) begin
          rdy_now = 1'b0;
          stall_left--;
        end else if (rnd_ready) begin
          rdy_now = ($urandom_range(0, 2) != 0);
        end
        s_if.blk_ready = rdy_now;
        if (rdy_now) got_q.push_back(s_if.blk_out);
        else begin
          n_stall++;
          prev_wait = 1'b1;
          prev_blk  = s_if.blk_out;
        end
        if (inj_out && !did_inj) begin
          inj_done  = 1'b1;
          inj_state = $urandom;
          did_inj   = 1'b1;
        end
      end else begin
        s_if.blk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (inj_coinc && s_if.perm_start) begin
        inj_done  = 1'b1;
        inj_state = $urandom;
      end
    end
    inj_done       = 1'b0;
    s_if.blk_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_if.en = 1'b0; s_if.state_in = '0; s_if.blk_ready = 1'b0;
    b_if.en = 1'b0; b_if.state_in = '0; b_if.blk_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({s_if.blk_valid, s_if.perm_start, s_if.rdy} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 000", {s_if.blk_valid, s_if.perm_start, s_if.rdy});
    end
    n_cmp++;
    if ({s_if.blk_out, s_if.perm_state_out, s_if.hash_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: blk=%h pso=%h hash=%h want 0", s_if.blk_out, s_if.perm_state_out, s_if.hash_out);
    end
    n_cmp++;
    if ({b_if.blk_valid, b_if.perm_start, b_if.rdy, b_if.blk_out} !== '0 ||
        b_if.hash_out !== '0 || b_if.perm_state_out !== '0) begin
      n_bad++;
      $display("FAIL reset_big: valid=%b start=%b rdy=%b blk=%h want all 0",
               b_if.blk_valid, b_if.perm_start, b_if.rdy, b_if.blk_out);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({s_if.blk_valid, s_if.rdy} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_release_idle: got %b want 00", {s_if.blk_valid, s_if.rdy});
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_blk[4];
    exp_blk = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    run_small(32'hA1B2C3D4, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (got_q.size() != NB) begin
      n_bad++;
      $display("FAIL basic_count: got %0d blocks want %0d", got_q.size(), NB);
    end
    for (int k = 0; k < NB && k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== exp_blk[k]) begin
        n_bad++;
        $display("FAIL basic_blk%0d: got %h want %h", k, got_q[k], exp_blk[k]);
      end
    end
    n_cmp++;
    if (n_perm != NB - 1) begin
      n_bad++;
      $display("FAIL basic_perm_starts: got %0d want %0d", n_perm, NB - 1);
    end
    n_cmp++;
    if (s_if.hash_out !== 32'hD4C3B2A1) begin
      n_bad++;
      $display("FAIL basic_hash: got %h want D4C3B2A1", s_if.hash_out);
    end
    n_cmp++;
    if (cyc != BASE_CYC) begin
      n_bad++;
      $display("FAIL basic_latency: rdy after %0d cycles want %0d", cyc, BASE_CYC);
    end
    s_if.en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_if.rdy !== 1'b0 || s_if.hash_out !== 32'hD4C3B2A1) begin
      n_bad++;
      $display("FAIL basic_release: rdy=%b hash=%h want 0 / D4C3B2A1", s_if.rdy, s_if.hash_out);
    end
  endtask

  task automatic test_backpressure();
    run_small(32'hA1B2C3D4, 1'b1, 1, 5, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (n_stall != 5 || hold_bad != 0) begin
      n_bad++;
      $display("FAIL bp_hold: stalls=%0d unstable=%0d want 5 / 0", n_stall, hold_bad);
    end
    n_cmp++;
    if (stall_perm != 0 || n_perm != NB - 1) begin
      n_bad++;
      $display("FAIL bp_perm: during_stall=%0d total=%0d want 0 / %0d", stall_perm, n_perm, NB - 1);
    end
    n_cmp++;
    if (got_q.size() != NB || s_if.hash_out !== 32'hD4C3B2A1) begin
      n_bad++;
      $display("FAIL bp_hash: blocks=%0d hash=%h want %0d / D4C3B2A1", got_q.size(), s_if.hash_out, NB);
    end
    n_cmp++;
    if (cyc != BASE_CYC + 5) begin
      n_bad++;
      $display("FAIL bp_latency: got %0d want %0d", cyc, BASE_CYC + 5);
    end
    s_if.en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hygiene();
    run_small(32'hA1B2C3D4, 1'b1, -1, 0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (got_q.size() != NB || n_perm != NB - 1) begin
      n_bad++;
      $display("FAIL hyg_counts: blocks=%0d perms=%0d want %0d / %0d", got_q.size(), n_perm, NB, NB - 1);
    end
    n_cmp++;
    if (s_if.hash_out !== 32'hD4C3B2A1) begin
      n_bad++;
      $display("FAIL hyg_hash: got %h want D4C3B2A1", s_if.hash_out);
    end
    n_cmp++;
    if (cyc != BASE_CYC) begin
      n_bad++;
      $display("FAIL hyg_latency: got %0d want %0d", cyc, BASE_CYC);
    end
    s_if.en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_retrigger();
    run_small(32'hA1B2C3D4, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({s_if.blk_valid, s_if.rdy} !== 2'b01) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: valid,rdy=%b want 01", i, {s_if.blk_valid, s_if.rdy});
      end
    end
    s_if.en = 1'b0;
    @(negedge clk);
    run_small(32'h11223344, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (s_if.hash_out !== 32'h44332211 || got_q.size() != NB) begin
      n_bad++;
      $display("FAIL retrig_hash: got %h (%0d blocks) want 44332211", s_if.hash_out, got_q.size());
    end
    s_if.en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int starts;
    starts = 0;
    s_if.state_in = 32'hA1B2C3D4; s_if.en = 1'b1; s_if.blk_ready = 1'b1;
    for (int i = 0; i < 100 && starts < 2; i++) begin
      @(negedge clk);
      if (s_if.perm_start) starts++;
    end
    n_cmp++;
    if (starts != 2) begin
      n_bad++;
      $display("FAIL rmid_reach_perm: saw %0d perm_start want 2", starts);
    end
    s_if.en = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({s_if.blk_valid, s_if.perm_start, s_if.rdy, s_if.blk_out} !== '0 ||
        s_if.perm_state_out !== '0 || s_if.hash_out !== '0) begin
      n_bad++;
      $display("FAIL rmid_async: valid=%b start=%b rdy=%b pso=%h hash=%h want all 0",
               s_if.blk_valid, s_if.perm_start, s_if.rdy, s_if.perm_state_out, s_if.hash_out);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({s_if.blk_valid, s_if.perm_start, s_if.rdy} !== 3'b000 || s_if.hash_out !== '0) begin
      n_bad++;
      $display("FAIL rmid_late_done: valid=%b start=%b rdy=%b hash=%h want idle",
               s_if.blk_valid, s_if.perm_start, s_if.rdy, s_if.hash_out);
    end
    run_small(32'hA1B2C3D4, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (s_if.hash_out !== 32'hD4C3B2A1 || cyc != BASE_CYC) begin
      n_bad++;
      $display("FAIL rmid_restart: hash=%h cycles=%0d want D4C3B2A1 / %0d", s_if.hash_out, cyc, BASE_CYC);
    end
    s_if.en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [SW-1:0] s;
    logic [HW-1:0] exp_h;
    bit            hold;
    for (int it = 0; it < 6; it++) begin
      s     = $urandom;
      hold  = 1'($urandom_range(0, 1));
      exp_h = ref_hash(s);
      run_small(s, hold, -1, 0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < NB; k++) begin
        n_cmp++;
        if (k >= got_q.size() || got_q[k] !== s[k*R +: R]) begin
          n_bad++;
          $display("FAIL rand%0d_blk%0d: got %h want %h", it, k,
                   (k < got_q.size()) ? got_q[k] : 8'hxx, s[k*R +: R]);
        end
      end
      n_cmp++;
      if (s_if.hash_out !== exp_h || got_q.size() != NB) begin
        n_bad++;
        $display("FAIL rand%0d_hash: got %h want %h", it, s_if.hash_out, exp_h);
      end
      n_cmp++;
      if (cyc != BASE_CYC + n_stall || hold_bad != 0 || n_perm != NB - 1) begin
        n_bad++;
        $display("FAIL rand%0d_timing: cycles=%0d want %0d unstable=%0d perms=%0d",
                 it, cyc, BASE_CYC + n_stall, hold_bad, n_perm);
      end
      s_if.en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_default_smoke();
    logic [BSW-1:0] s;
    logic [BHW-1:0] exp_h;
    int nblk, badblk, nperm, c;
    for (int i = 0; i < BSW / 8; i++) s[i*8 +: 8] = 8'($urandom);
    s[7:0] = 8'h5A;
    exp_h = '0;
    for (int k = 0; k < BNB; k++) exp_h[k*8 +: 8] = 8'h5A;
    nblk = 0; badblk = 0; nperm = 0; c = 0;
    b_if.state_in = s; b_if.blk_ready = 1'b1; b_if.en = 1'b1;
    while (1) begin
      @(negedge clk);
      c++;
      b_if.en = 1'b0;
      if (b_if.rdy || c > 2000) break;
      if (b_if.perm_start) nperm++;
      if (b_if.blk_valid) begin
        nblk++;
        if (b_if.blk_out !== 8'h5A) badblk++;
      end
    end
    n_cmp++;
    if (nblk != BNB || badblk != 0) begin
      n_bad++;
      $display("FAIL big_blocks: got %0d (%0d wrong) want %0d of 5a", nblk, badblk, BNB);
    end
    n_cmp++;
    if (nperm != BNB - 1) begin
      n_bad++;
      $display("FAIL big_perm_starts: got %0d want %0d", nperm, BNB - 1);
    end
    n_cmp++;
    if (b_if.hash_out !== exp_h) begin
      n_bad++;
      $display("FAIL big_hash: got %h want %h", b_if.hash_out, exp_h);
    end
    n_cmp++;
    if (c != BIG_CYC) begin
      n_bad++;
      $display("FAIL big_latency: got %0d want %0d", c, BIG_CYC);
    end
    @(negedge clk);
    n_cmp++;
    if (b_if.rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL big_rdy_clear: got %b want 0", b_if.rdy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_hygiene();
    test_retrigger();
    test_reset_mid();
    test_random();
    test_default_smoke();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
